exec_unit_mc: RTL

Parametrised, handshaked execute stage for the next-generation RISC-V core. It is the successor to the single-cycle ALU/immediate unit and covers four functions:
- a full immediate generator for I/S/B/J/U formats;
- operand-B selection;
- an extended single-cycle ALU;
- an iterative unsigned multiply/divide engine for the M-subset.

Results leave through a one-deep registered output with valid/ready flow control. The block sits between decode/register-read and writeback/branch-resolve in the multi-cycle pipeline.

---
 rtl/exec_unit_mc.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit_mc.sv
// ---------------------------------------------------------------------------
// exec_unit_mc
//   Handshaked execute stage: immediate generator, operand-B select, a
//   single-cycle ALU and an iterative radix-2 unsigned multiply/divide engine.
//   Results leave through a one-deep registered output with valid/ready flow
//   control.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (operation accepted when both high)
//   srca, writedata       operand A, register operand B
//   instr, immsrc         instruction word and immediate format select
//   alusrc                1: srcb = immext, 0: srcb = writedata
//   alucontrol            ALU operation select
//   md_en, md_op          route to mul/div engine; MUL/MULHU/DIVU/REMU
//   immext                combinational immediate from instr/immsrc
//   out_valid / out_ready output handshake
//   result, zero          registered result and (result == 0) flag
// ---------------------------------------------------------------------------
module exec_unit_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] writedata,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    input  logic            alusrc,
    input  logic [3:0]      alucontrol,
    input  logic            md_en,
    input  logic [1:0]      md_op,
    output logic [XLEN-1:0] immext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Architectural state
    logic [0:0]      state_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] hi_r;       // product upper half / partial remainder
    logic [XLEN-1:0] lo_r;       // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] opb_r;      // multiplicand / divisor
    logic [1:0]      md_op_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            out_valid_r;

    // Combinational nets
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] immext_s;
    logic [XLEN-1:0] srcb_s;
    logic [CW-1:0]   shamt_s;
    logic [XLEN-1:0] alu_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN-1:0] rem_shift_s;
    logic            div_ge_s;
    logic [XLEN-1:0] step_hi_s;
    logic [XLEN-1:0] step_lo_s;
    logic [XLEN-1:0] md_result_s;
    logic            accept_s;
    logic            alu_wr_s;
    logic            md_wr_s;
    logic            unused_opcode_s;

    // The opcode field plays no part in immediate extraction.
    assign unused_opcode_s = ^instr[6:0];

    // Immediate extraction into a 32-bit signed value, then sign-extension to XLEN.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (immsrc)
            3'b000:  imm32_s = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100:  imm32_s = {instr[31:12], 12'h000};
            default: imm32_s = 32'h0000_0000;
        endcase
    end

    assign immext_s = XLEN'($signed(imm32_s));
    assign immext   = immext_s;

    // Operand-B select.
    always_comb begin
        if (alusrc) begin
            srcb_s = immext_s;
        end else begin
            srcb_s = writedata;
        end
    end

    assign shamt_s = srcb_s[CW-1:0];

    // Single-cycle ALU.
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (alucontrol)
            4'b0000: alu_s = srca + srcb_s;
            4'b0001: alu_s = srca - srcb_s;
            4'b0010: alu_s = srca & srcb_s;
            4'b0011: alu_s = srca | srcb_s;
            4'b0100: alu_s = srca ^ srcb_s;
            4'b0101: alu_s = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb_s))};
            4'b0110: alu_s = {{(XLEN-1){1'b0}}, (srca < srcb_s)};
            4'b0111: alu_s = srca << shamt_s;
            4'b1000: alu_s = srca >> shamt_s;
            4'b1001: alu_s = $unsigned($signed(srca) >>> shamt_s);
            4'b1010: alu_s = srcb_s;
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // One mul/div iteration. Multiply: conditional add into the upper half,
    // then shift the whole product right. Divide: restoring step on the
    // remainder with the next dividend bit shifted in from lo_r's MSB; a zero
    // divisor naturally yields an all-ones quotient and remainder = dividend.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        rem_shift_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
        div_ge_s    = ({hi_r, lo_r[XLEN-1]} >= {1'b0, opb_r});
        step_hi_s   = hi_r;
        step_lo_s   = lo_r;
        if (!md_op_r[1]) begin
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end else begin
            if (div_ge_s) begin
                step_hi_s = rem_shift_s - opb_r;
                step_lo_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                step_hi_s = rem_shift_s;
                step_lo_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end
    end

    // MUL/DIVU take the low register, MULHU/REMU the high register.
    always_comb begin
        if (md_op_r[0]) begin
            md_result_s = step_hi_s;
        end else begin
            md_result_s = step_lo_s;
        end
    end

    assign in_ready = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready;
    assign alu_wr_s = accept_s && !md_en;
    // Completion only proceeds once the output register is free.
    assign md_wr_s  = (state_r == ST_BUSY) && (cnt_r == CNT_LAST) && (!out_valid_r || out_ready);

    // Control FSM and mul/div iteration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= {XLEN{1'b0}};
            opb_r   <= {XLEN{1'b0}};
            md_op_r <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && md_en) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= {CW{1'b0}};
                        hi_r    <= {XLEN{1'b0}};
                        lo_r    <= srca;
                        opb_r   <= srcb_s;
                        md_op_r <= md_op;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        hi_r  <= step_hi_s;
                        lo_r  <= step_lo_s;
                    end else if (md_wr_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // One-deep output register with valid/ready hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (alu_wr_s) begin
            result_r    <= alu_s;
            zero_r      <= (alu_s == {XLEN{1'b0}});
            out_valid_r <= 1'b1;
        end else if (md_wr_s) begin
            result_r    <= md_result_s;
            zero_r      <= (md_result_s == {XLEN{1'b0}});
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign result    = result_r;
    assign zero      = zero_r;
    assign out_valid = out_valid_r;

endmodule
